// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. A single 1-bit add cell
// (two half adders plus an OR for the carry) walks two WIDTH-bit operands
// LSB-first, one bit per clock, behind a start/busy/done handshake.
// Optional build macro: SERIAL_ADD_SUB_EN adds a 'sub' input that turns the
// operation into a - b (two's complement via ~b and carry-in of 1).

module half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_sh_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q, cout_q;
    logic [CNT_W-1:0]   cnt_q;

    // Shared bit cell: HA1 adds the operand bits, HA2 folds in the carry.
    logic s1, c1, s_bit, c2;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;

    half_adder u_ha1 (.x_i(a_sh_q[0]), .y_i(b_sh_q[0]), .s_o(s1),    .c_o(c1));
    half_adder u_ha2 (.x_i(s1),        .y_i(carry_q),   .s_o(s_bit), .c_o(c2));

    assign carry_d = c1 | c2;
    assign res_d   = {s_bit, res_sh_q[WIDTH-1:1]};

    // Operand capture values; subtraction inverts b and injects a carry of 1.
    logic [WIDTH-1:0] b_cap_d;
    logic             cin_d;
`ifdef SERIAL_ADD_SUB_EN
    assign b_cap_d = sub ? ~b : b;
    assign cin_d   = sub;
`else
    assign b_cap_d = b;
    assign cin_d   = 1'b0;
`endif

    // Sequencer FSM plus datapath registers; reset wins over every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b_cap_d;
                        carry_q <= cin_d;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_sh_q <= res_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= carry_d;
                    if (cnt_q == LAST) begin
                        // Last bit: publish result; counter rests at 0, never past WIDTH-1.
                        cnt_q   <= '0;
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register.
    assign busy = (state_q == RUN) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed checks of serial_add_ctrl against a plain
// arithmetic reference (a+b, or a-b with cout = no-borrow).
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         sub;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from idle: checks latency, hold during RUN, result.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
        logic [W:0] full;
        logic       ec;
        int         n;
        start = 1'b1; a = ta; b = tb_v; sub = ts;
        tick();                         // E0: accepted
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        chk("busy_e0", busy, 1);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            chk("hold_sum", sum, prev_sum);
            chk("hold_cout", cout, prev_cout);
            tick();
            n++;
        end
        chk("latency", n, W);
        if (ts) begin
            full = {1'b0, ta - tb_v};
            ec   = (ta >= tb_v);
        end else begin
            full = {1'b0, ta} + {1'b0, tb_v};
            ec   = full[W];
        end
        chk("sum", sum, full[W-1:0]);
        chk("cout", cout, ec);
        chk("busy_done", busy, 1);
        tick();
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("sum_after", sum, full[W-1:0]);
        prev_sum  = full[W-1:0];
        prev_cout = ec;
    endtask

    initial begin
        int ndone;
        int t1, t2, cyc;
        logic [W-1:0] dsum;

        rst = 1'b1; start = 1'b1; sub = 1'b0;
        a = W'($urandom); b = W'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_sum", sum, 0);
            chk("rst_cout", cout, 0);
        end
        rst = 1'b0; start = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        tick();

        do_op(8'h3C, 8'h5A, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0);

        // start while busy is dropped, not queued
        start = 1'b1; a = 8'h01; b = 8'h02; sub = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; a = 8'h10; b = 8'h10;
        tick();
        start = 1'b0;
        ndone = 0; dsum = '0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                ndone++;
                dsum = sum;
            end
            tick();
        end
        chk("busy_ignore_cnt", ndone, 1);
        chk("busy_ignore_sum", dsum, 8'h03);
        chk("busy_ignore_idle", busy, 0);
        chk("busy_ignore_hold", sum, 8'h03);

        // reset mid-RUN discards the partial result
        start = 1'b1; a = 8'hAA; b = 8'h55;
        tick();                         // E0
        start = 1'b0;
        tick(); tick(); tick();         // after E0+3
        rst = 1'b1;
        tick();                         // E0+4
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        tick();                         // E0+5
        chk("midrst_done", done, 0);
        prev_sum = '0; prev_cout = 1'b0;
        do_op(8'h01, 8'h01, 1'b0);      // accepted at E0+6

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h05, 8'h07, 1'b1);
        do_op(8'h07, 8'h05, 1'b1);
`endif

        for (int i = 0; i < 30; i++) begin
            logic ts;
`ifdef SERIAL_ADD_SUB_EN
            ts = 1'($urandom);
`else
            ts = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), ts);
            if (($urandom % 3) == 0) tick();
        end

        // start held high: one op per W+2 cycles
        start = 1'b1; a = 8'h21; b = 8'h12; sub = 1'b0;
        t1 = -1; t2 = -1; cyc = 0;
        while (t2 < 0 && cyc < 40) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                if (t1 < 0) t1 = cyc;
                else        t2 = cyc;
            end
        end
        chk("b2b_gap", (t1 >= 0 && t2 >= 0) ? t2 - t1 : 0, W + 2);
        chk("b2b_sum", sum, 8'h33);
        start = 1'b0;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("b2b_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. One shared 1-bit add cell, built from two half_adder instances plus an OR for the carry, processes two WIDTH-bit operands LSB-first over WIDTH cycles. A start/busy/done handshake lets a requester issue one addition at a time. This trades area for latency wherever several narrow additions share a single adder cell.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, high while state is DONE
sum  output  WIDTH  result; held until the next result is loaded
cout  output  1  final carry-out; held with sum

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry and counter all cleared. Reset has priority over everything, including mid-RUN; a partial result is discarded and never loaded into sum.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- IDLE:
  - start=1 at an edge: a_sh<=a, b_sh<=b, carry<=0, cnt<=0, state<=RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - Bit cell inputs: x=a_sh[0], y=b_sh[0], ci=carry.
  - HA1(x,y)->(s1,c1); HA2(s1,ci)->(s,c2).
  - res_sh <= {s, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry<=c1|c2; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: sum<={s, res_sh[WIDTH-1:1]}, cout<=c1|c2, state<=DONE.
- DONE: done=1 for exactly one cycle; state<=IDLE at the next edge. start is ignored here.
- Latency: start accepted at edge E0 -> sum/cout valid and done=1 after edge E0+WIDTH. Throughput is one op per WIDTH+2 cycles when start is held high.
- start while busy=1: ignored, not queued. a/b changes after capture have no effect.
- Arithmetic: sum = (a+b) mod 2^WIDTH; cout = bit WIDTH of a+b. Wrap-around is normal; no overflow flag.
- sum/cout hold their value from DONE until the next DONE or rst; they do not toggle during RUN.
- Counter never exceeds WIDTH-1; no other states are reachable. Any illegal state encoding -> IDLE on the next edge.

Optional Feature:
SERIAL_ADD_SUB_EN:
- Defined: adds input port sub (1 bit, captured with a/b on accepted start).
  - sub=1: b_sh<=~b and carry<=1 at capture, so result = a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned); cout=0 means borrow.
  - sub=0: identical to add mode.
- Undefined: no sub port; add only; behaviour exactly as above.

Test Plan:
1. Reset check: rst=1 for 2 cycles, start=1 held -> busy=0, done=0, sum=8'h00, cout=0 throughout reset.
2. Basic add: WIDTH=8, a=8'h3C, b=8'h5A, start pulse at E0 -> busy high from E0; done=1 only in the cycle after E0+8; sum=8'h96, cout=0.
3. Wrap/carry: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
4. Start while busy: start pulses at E0 (a=1, b=2) and again at E0+3 (a=8'h10, b=8'h10) -> exactly one done pulse; sum=8'h03. No second op runs. sum holds 8'h03 until the next accepted start completes.
5. Reset mid-RUN: start at E0 with a=8'hAA, b=8'h55; rst=1 at E0+4 -> IDLE, sum=0, cout=0, no done pulse. A new start at E0+6 (a=1, b=1) -> sum=8'h02 after 8 cycles.
6. SERIAL_ADD_SUB_EN defined:
   - a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0.
   - a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.
   - Back-to-back with start held high -> one op per 10 cycles.
